halut_decoder: RTL and testbench

HALUT_DECODER -- requirements
Module: halut_decoder

---
 rtl/halut_decoder.sv | 175 +++++++++++++++++
 tb/tb_halut_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halut_decoder.sv
// -----------------------------------------------------------------------------
// halut_decoder
//
// Purpose:
//   Decoder stage of a HALUT (hashed lookup-table) matrix multiply. The encoder
//   delivers one (codebook, prototype) index pair per accepted cycle. The
//   decoder reads the matching signed LUT entry and adds up C consecutive
//   entries. It emits one result per group of C inputs, two cycles after the
//   group's last input.
//
// Configuration:
//   HALUT_DECODER_SATURATE_EN - when defined, every accumulator add clamps to
//   the signed AccWidth range. When undefined, adds wrap in two's complement.
//
// Ports:
//   clk_i      - clock, all state on the rising edge
//   rst_ni     - asynchronous active-low reset (clears LUT and pipeline)
//   c_addr_i   - codebook index from the encoder
//   k_addr_i   - prototype index from the encoder
//   valid_i    - qualifies c_addr_i/k_addr_i for one cycle
//   decoder_i  - enable; low idles the block and discards in-flight work
//   waddr_i    - LUT write address {c, k}
//   wdata_i    - LUT write data (signed)
//   we_i       - LUT write enable (honoured regardless of decoder_i)
//   result_o   - signed sum of C LUT entries, held until the next result
//   valid_o    - one-cycle pulse marking a new result_o
// -----------------------------------------------------------------------------
package halut_pkg;
  localparam int unsigned K             = 16;
  localparam int unsigned C             = 4;
  localparam int unsigned DataTypeWidth = 16;
endpackage

module halut_decoder #(
  parameter  int unsigned K             = halut_pkg::K,
  parameter  int unsigned C             = halut_pkg::C,
  parameter  int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter  int unsigned AccWidth      = 32,
  localparam int unsigned TreeDepth     = $clog2(K),
  localparam int unsigned CAddrWidth    = $clog2(C),
  localparam int unsigned LutAddrWidth  = $clog2(C * K)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [CAddrWidth-1:0]           c_addr_i,
  input  logic [TreeDepth-1:0]            k_addr_i,
  input  logic                            valid_i,
  input  logic                            decoder_i,
  input  logic [LutAddrWidth-1:0]         waddr_i,
  input  logic signed [DataTypeWidth-1:0] wdata_i,
  input  logic                            we_i,
  output logic signed [AccWidth-1:0]      result_o,
  output logic                            valid_o
);

  typedef enum logic {IDLE, ACCUM} state_e;

  localparam logic [CAddrWidth-1:0] LastCnt = CAddrWidth'(C - 1);

  state_e                            state_reg, state_next;
  logic                              flush, accept;
  logic [CAddrWidth-1:0]             in_cnt_reg;
  logic                              s1_valid_reg, s1_first_reg, s1_last_reg;
  logic signed [AccWidth-1:0]        s1_entry_reg;
  logic signed [AccWidth-1:0]        acc_reg;
  logic                              s2_done_reg;
  logic signed [AccWidth-1:0]        result_reg;
  logic                              valid_reg;
  logic signed [AccWidth-1:0]        add_sum;
  logic signed [DataTypeWidth-1:0]   lut_rd_data;
  logic signed [AccWidth-1:0]        lut_rd_ext;
  logic signed [DataTypeWidth-1:0]   lut_entries [C*K];

  // LUT kept in flops: it needs an asynchronous clear and a combinational read,
  // neither of which a block RAM offers.
  genvar gi;
  generate
    for (gi = 0; gi < int'(C * K); gi++) begin : g_lut
      logic signed [DataTypeWidth-1:0] entry_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          entry_reg <= '0;
        end else if (we_i && (waddr_i == LutAddrWidth'(gi))) begin
          entry_reg <= wdata_i;
        end
      end
      assign lut_entries[gi] = entry_reg;
    end
  endgenerate

  // A write in the same cycle lands at the edge, so this read sees old data.
  assign lut_rd_data = lut_entries[{c_addr_i, k_addr_i}];
  assign lut_rd_ext  = {{(AccWidth - DataTypeWidth){lut_rd_data[DataTypeWidth-1]}}, lut_rd_data};

  // FSM: the decoder only runs while decoder_i is high.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (decoder_i)  state_next = ACCUM;
      ACCUM:   if (!decoder_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign flush  = (state_next == IDLE);
  assign accept = (state_next == ACCUM) && valid_i;

`ifdef HALUT_DECODER_SATURATE_EN
  localparam logic signed [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};
  logic signed [AccWidth:0] add_wide;

  assign add_wide = {acc_reg[AccWidth-1], acc_reg} + {s1_entry_reg[AccWidth-1], s1_entry_reg};

  // The two top bits of the widened sum disagree only on overflow. The top
  // bit then gives the true sign, so it picks the clamp direction.
  always_comb begin
    add_sum = add_wide[AccWidth-1:0];
    if (add_wide[AccWidth] != add_wide[AccWidth-1]) begin
      add_sum = add_wide[AccWidth] ? AccMin : AccMax;
    end
  end
`else
  assign add_sum = acc_reg + s1_entry_reg;
`endif

  // Pipeline. Stage 1 latches the entry, stage 2 accumulates, and the output
  // register publishes the finished group one edge after its final add.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      in_cnt_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_entry_reg <= '0;
      acc_reg      <= '0;
      s2_done_reg  <= 1'b0;
      result_reg   <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        // Drop the partial group and everything in flight. result_o is kept.
        in_cnt_reg   <= '0;
        s1_valid_reg <= 1'b0;
        acc_reg      <= '0;
        s2_done_reg  <= 1'b0;
        valid_reg    <= 1'b0;
      end else begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_entry_reg <= lut_rd_ext;
          s1_first_reg <= (in_cnt_reg == '0);
          s1_last_reg  <= (in_cnt_reg == LastCnt);
          in_cnt_reg   <= (in_cnt_reg == LastCnt) ? '0 : in_cnt_reg + 1'b1;
        end
        // A group's first entry replaces the accumulator. The next group can
        // therefore start right behind the previous one with no bubble.
        if (s1_valid_reg) begin
          acc_reg <= s1_first_reg ? s1_entry_reg : add_sum;
        end
        s2_done_reg <= s1_valid_reg && s1_last_reg;
        valid_reg   <= s2_done_reg;
        if (s2_done_reg) begin
          result_reg <= acc_reg;
        end
      end
    end
  end

  assign result_o = result_reg;
  assign valid_o  = valid_reg;

endmodule

// File: tb/tb_halut_decoder.sv
// -----------------------------------------------------------------------------
// tb_halut_decoder
//
// Self-checking bench for halut_decoder (K=16, C=4, DataTypeWidth=16,
// AccWidth=17). A behavioural model keeps a LUT image, the current group as a
// queue, and a queue of results due on a given edge. Every cycle the bench
// compares valid_o and result_o against the model. Directed scenarios also
// check pulse counts and values against constants. Honours
// HALUT_DECODER_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_halut_decoder;

  localparam int K   = 16;
  localparam int C   = 4;
  localparam int DW  = 16;
  localparam int AW  = 17;
  localparam int CAW = 2;
  localparam int TD  = 4;
  localparam int LAW = 6;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [CAW-1:0]        c_addr_i = '0;
  logic [TD-1:0]         k_addr_i = '0;
  logic                  valid_i = 1'b0;
  logic                  decoder_i = 1'b0;
  logic [LAW-1:0]        waddr_i = '0;
  logic signed [DW-1:0]  wdata_i = '0;
  logic                  we_i = 1'b0;
  logic signed [AW-1:0]  result_o;
  logic                  valid_o;

  halut_decoder #(
    .K(K), .C(C), .DataTypeWidth(DW), .AccWidth(AW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .c_addr_i(c_addr_i), .k_addr_i(k_addr_i),
    .valid_i(valid_i), .decoder_i(decoder_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .we_i(we_i), .result_o(result_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint due;
    longint val;
  } pend_t;

  longint lut_m [C*K];
  longint grp[$];
  pend_t  pend[$];
  longint edge_idx   = 0;
  longint exp_result = 0;
  int     pulses     = 0;
  longint last_pulse = 0;
  longint last_pulse_edge = 0;
  longint prev_pulse_edge = 0;

  localparam longint AccSpan = 64'sd1 <<< AW;
  localparam longint AccHi   = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint AccLo   = -(64'sd1 <<< (AW - 1));

  function automatic longint to_acc(input longint v);
    longint r;
    r = v % AccSpan;
    if (r < 0) r += AccSpan;
    if (r > AccHi) r -= AccSpan;
    return r;
  endfunction

  // Sum of the current group, one add at a time like a running accumulator.
  function automatic longint group_sum();
    longint s;
    s = grp[0];
    for (int i = 1; i < grp.size(); i++) begin
`ifdef HALUT_DECODER_SATURATE_EN
      s = s + grp[i];
      if (s > AccHi) s = AccHi;
      if (s < AccLo) s = AccLo;
`else
      s = to_acc(s + grp[i]);
`endif
    end
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < C*K; i++) lut_m[i] = 0;
    grp.delete();
    pend.delete();
    exp_result = 0;
  endfunction

  // Apply the model for the coming edge, clock it, then compare outputs.
  task automatic tick();
    longint exp_v;
    edge_idx++;
    if (!decoder_i) begin
      grp.delete();
      pend.delete();
    end else if (valid_i) begin
      grp.push_back(lut_m[{c_addr_i, k_addr_i}]);
      if (grp.size() == C) begin
        pend.push_back('{edge_idx + 2, group_sum()});
        grp.delete();
      end
    end
    if (we_i) lut_m[waddr_i] = longint'(wdata_i);
    @(posedge clk_i);
    #1;
    exp_v = 0;
    if (pend.size() > 0 && pend[0].due == edge_idx) begin
      exp_v = 1;
      exp_result = pend[0].val;
      void'(pend.pop_front());
    end
    check_eq("valid_o", longint'(valid_o), exp_v);
    check_eq("result_o", longint'(result_o), exp_result);
    if (valid_o) begin
      pulses++;
      last_pulse = result_o;
      prev_pulse_edge = last_pulse_edge;
      last_pulse_edge = edge_idx;
      $display("edge %0d: result %0d", edge_idx, result_o);
    end
  endtask

  task automatic write_lut(input int addr, input int data);
    valid_i = 1'b0;
    we_i    = 1'b1;
    waddr_i = LAW'(addr);
    wdata_i = DW'(data);
    tick();
    we_i    = 1'b0;
  endtask

  task automatic feed(input int c, input int k);
    valid_i  = 1'b1;
    c_addr_i = CAW'(c);
    k_addr_i = TD'(k);
    tick();
    valid_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic feed_base();
    feed(0, 3); feed(1, 5); feed(2, 0); feed(3, 15);
  endtask

  task automatic feed_ones();
    feed(0, 1); feed(1, 1); feed(2, 1); feed(3, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sat_exp;
    model_reset();
    #22;
    check_eq("rst_result", longint'(result_o), 0);
    check_eq("rst_valid", longint'(valid_o), 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Basic group: 10 - 4 + 7 + 100.
    write_lut(3, 10); write_lut(21, -4); write_lut(32, 7); write_lut(63, 100);
    write_lut(1, 1);  write_lut(17, 1);  write_lut(33, 1); write_lut(49, 1);
    decoder_i = 1'b1;
    idle(1);
    pulses = 0;
    feed_base();
    idle(4);
    check_eq("basic_pulses", pulses, 1);
    check_eq("basic_value", last_pulse, 113);

    // Two back-to-back groups.
    pulses = 0;
    feed_base();
    feed_ones();
    idle(4);
    check_eq("b2b_pulses", pulses, 2);
    check_eq("b2b_second", last_pulse, 4);
    check_eq("b2b_gap", last_pulse_edge - prev_pulse_edge, 4);

    // Gaps between inputs.
    pulses = 0;
    feed(0, 3); idle(1); feed(1, 5); idle(1); feed(2, 0); idle(1); feed(3, 15);
    idle(4);
    check_eq("gap_pulses", pulses, 1);
    check_eq("gap_value", last_pulse, 113);

    // Disable mid-group: the partial group is discarded.
    pulses = 0;
    feed(0, 3); feed(1, 5);
    decoder_i = 1'b0;
    idle(1);
    decoder_i = 1'b1;
    feed_ones();
    idle(4);
    check_eq("abort_pulses", pulses, 1);
    check_eq("abort_value", last_pulse, 4);

    // Overflow: saturate or wrap.
    write_lut(2, 32767); write_lut(18, 32767); write_lut(34, 32767); write_lut(50, 32767);
    pulses = 0;
    feed(0, 2); feed(1, 2); feed(2, 2); feed(3, 2);
    idle(4);
`ifdef HALUT_DECODER_SATURATE_EN
    sat_exp = 65535;
`else
    sat_exp = -4;
`endif
    check_eq("ovf_pulses", pulses, 1);
    check_eq("ovf_value", last_pulse, sat_exp);

    // Asynchronous reset mid-group.
    feed(0, 3); feed(1, 5);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_result", longint'(result_o), 0);
    check_eq("arst_valid", longint'(valid_o), 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    edge_idx++;
    pulses = 0;
    feed_base();
    idle(4);
    check_eq("post_rst_pulses", pulses, 1);
    check_eq("post_rst_value", last_pulse, 0);

    // Randomised traffic.
    pulses = 0;
    for (int i = 0; i < 800; i++) begin
      decoder_i = ($urandom_range(0, 24) != 0);
      valid_i   = ($urandom_range(0, 3) != 0);
      c_addr_i  = CAW'($urandom);
      k_addr_i  = TD'($urandom);
      we_i      = ($urandom_range(0, 3) == 0);
      waddr_i   = LAW'($urandom);
      case ($urandom_range(0, 3))
        0:       wdata_i = 16'sh7FFF;
        1:       wdata_i = -16'sh8000;
        default: wdata_i = DW'($urandom);
      endcase
      tick();
    end
    valid_i = 1'b0;
    we_i    = 1'b0;
    decoder_i = 1'b1;
    idle(4);
    check_eq("rand_pulses_seen", longint'(pulses > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
